// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative RV32M/RV64M multiply/divide unit, one result bit per cycle
module muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] s1,
    input  logic [XLEN-1:0] s2,
    input  logic [2:0]      op,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    // upper half: partial product / partial remainder; lower half: multiplier / dividend-quotient
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic [2:0]        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div0;
    logic              r_ovf;

    logic              w_s1_sgn;
    logic              w_s2_sgn;
    logic              w_neg1;
    logic              w_neg2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    assign in_ready = (r_state == S_IDLE);

    // operand signedness by funct3
    always_comb begin
        w_s1_sgn = 1'b0;
        w_s2_sgn = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_s1_sgn = 1'b1;
                w_s2_sgn = 1'b1;
            end
            3'b010:  w_s1_sgn = 1'b1;
            default: ;
        endcase
    end

    assign w_neg1 = w_s1_sgn & s1[XLEN-1];
    assign w_neg2 = w_s2_sgn & s2[XLEN-1];
    assign w_abs1 = w_neg1 ? -s1 : s1;
    assign w_abs2 = w_neg2 ? -s2 : s2;

    // shift-add step: add multiplicand when multiplier lsb is set, then shift right
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // restoring step: the remainder is always below the divisor, so the msb of the
    // (XLEN+1)-bit trial difference is a clean borrow indicator
    assign w_trial    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_b};
    assign w_div_next = w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                      : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // sign correction, special-case forcing and half selection
    always_comb begin
        w_prod = r_neg_q ? -r_acc : r_acc;
        w_quo  = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        if (r_div0) begin
            w_quo = '1;
        end else if (r_ovf) begin
            w_quo = {1'b1, {(XLEN-1){1'b0}}};
            w_rem = '0;
        end
        case (r_op)
            3'b000:                 w_result = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_result = w_quo;
            default:                w_result = w_rem;
        endcase
    end

    // control FSM with datapath; kill overrides accept and release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
        end else if (kill) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_CALC;
                        r_cnt   <= '0;
                        r_acc   <= {{XLEN{1'b0}}, w_abs1};
                        r_b     <= w_abs2;
                        r_op    <= op;
                        r_neg_q <= w_neg1 ^ w_neg2;
                        r_neg_r <= w_neg1;
                        r_div0  <= (s2 == '0);
                        r_ovf   <= (op[2] & ~op[0]) & (s1 == {1'b1, {(XLEN-1){1'b0}}}) & (&s2);
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[2] ? w_div_next : w_mul_next;
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_cnt   <= '0;
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    out       <= w_result;
                    out_valid <= 1'b1;
                    r_state   <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - randomized self-checking bench for muldiv against an arithmetic model
module tb_muldiv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [2:0]  op;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s1        (s1),
        .s2        (s2),
        .op        (op),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (res)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // RISC-V M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0)   r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0)   r = a;
                else if (ovf) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] c [5];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF; c[3] = 32'h8000_0000; c[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 300)) - 32'd150;
        return $urandom;
    endfunction

    // one full transaction: accept, latency, result, optional backpressure, release
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          n;
        int          w;
        logic        bad;
        logic [31:0] exp;
        exp = ref_model(o, a, b);
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        s1        = a;
        s2        = b;
        op        = o;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s1       = $urandom;
        s2       = $urandom;
        op       = 3'($urandom_range(0, 7));
        n   = 0;
        bad = 1'b0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) bad = 1'b1;
        end
        check({tag, "_latency"}, n + 1, 34);
        check({tag, "_busy"}, bad, 0);
        check({tag, "_out"}, res, exp);
        if (hold > 0) begin
            bad = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                if (res !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
            end
            check({tag, "_hold"}, bad, 0);
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
        check({tag, "_retain"}, res, exp);
    endtask

    initial begin
        int          n;
        logic        seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        kill      = 1'b0;
        out_ready = 1'b1;
        s1        = '0;
        s2        = '0;
        op        = '0;
        #22;
        check("reset_state", {out_valid, in_ready, res}, {2'b01, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7x-3",   3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        check("mul_7x-3_abs", res, 32'hFFFF_FFEB);
        run_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        check("mulh_min_abs", res, 32'h4000_0000);
        run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulhu_max_abs", res, 32'hFFFF_FFFE);
        run_op("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulhsu_m1_abs", res, 32'hFFFF_FFFF);
        run_op("div_-7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_-7_2_abs", res, 32'hFFFF_FFFD);
        run_op("rem_-7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        check("rem_-7_2_abs", res, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
        check("divu_100_7_abs", res, 32'd14);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 0);
        check("remu_100_7_abs", res, 32'd2);
        run_op("div_5_0",    3'd4, 32'd5, 32'd0, 0);
        check("div_5_0_abs", res, 32'hFFFF_FFFF);
        run_op("remu_5_0",   3'd7, 32'd5, 32'd0, 0);
        check("remu_5_0_abs", res, 32'd5);
        run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_abs", res, 32'h8000_0000);
        run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("rem_ovf_abs", res, 32'h0);
        run_op("backpressure", 3'd0, 32'd1234, 32'd5678, 10);

        for (int i = 0; i < 48; i++) begin
            run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick(), pick(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        // request alongside kill in IDLE is not accepted
        @(negedge clk);
        in_valid = 1'b1;
        kill     = 1'b1;
        s1       = 32'd9;
        s2       = 32'd3;
        op       = 3'd5;
        @(negedge clk);
        in_valid = 1'b0;
        kill     = 1'b0;
        check("kill_blocks_accept", in_ready, 1);

        // kill mid-calculation
        in_valid  = 1'b1;
        out_ready = 1'b1;
        s1        = 32'd1000;
        s2        = 32'd7;
        op        = 3'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen     = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_idle", {out_valid, in_ready}, 2'b01);
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("kill_no_valid", seen, 0);

        // reset while holding a result in DONE
        in_valid  = 1'b1;
        out_ready = 1'b0;
        s1        = 32'd77;
        s2        = 32'd3;
        op        = 3'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_pre_valid", {out_valid, res}, {1'b1, 32'd231});
        rst_n = 1'b0;
        #1;
        check("rst_in_done", {out_valid, in_ready, res}, {2'b01, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 0);
        check("divu_9_3_abs", res, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
